// File: rtl/pmcc_loop_ctrl_if.sv
// Decoder, PC and loop-LIFO signals of the PMC loop sequencer.
// PMCC_LOOP_INFINITE_EN adds the loop_break strobe.
interface pmcc_loop_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int ITER_W = 14
);
  logic                     clear;
  logic                     loop_start;
  logic [ADDR_W-1:0]        start_addr;
  logic [ITER_W-1:0]        iterations;
  logic                     loop_end;
`ifdef PMCC_LOOP_INFINITE_EN
  logic                     loop_break;
`endif
  logic                     busy;
  logic                     jump_req;
  logic [ADDR_W-1:0]        jump_addr;
  logic [3:0]               depth;
  logic                     error;
  logic                     lifo_push;
  logic [ADDR_W+ITER_W-1:0] lifo_wdata;
  logic                     lifo_pop;
  logic [ADDR_W+ITER_W-1:0] lifo_rdata;
  logic                     lifo_full;
  logic                     lifo_empty;

  modport master (
`ifdef PMCC_LOOP_INFINITE_EN
    input  loop_break,
`endif
    input  clear, loop_start, start_addr, iterations, loop_end,
    input  lifo_rdata, lifo_full, lifo_empty,
    output busy, jump_req, jump_addr, depth, error,
    output lifo_push, lifo_wdata, lifo_pop
  );

  modport slave (
`ifdef PMCC_LOOP_INFINITE_EN
    output loop_break,
`endif
    output clear, loop_start, start_addr, iterations, loop_end,
    output lifo_rdata, lifo_full, lifo_empty,
    input  busy, jump_req, jump_addr, depth, error,
    input  lifo_push, lifo_wdata, lifo_pop
  );
endinterface

// File: rtl/pmcc_loop_ctrl.sv
// Loop sequencer: working loop register, spill/restore through the loop LIFO, jump requests.
// Optional macro PMCC_LOOP_INFINITE_EN: iterations==0 means infinite, adds loop_break.
module pmcc_loop_ctrl #(
  parameter int ADDR_W = 10,
  parameter int ITER_W = 14,
  parameter int DEPTH  = 10
) (
  input logic            clk,
  input logic            rst,
  pmcc_loop_ctrl_if.master bus
);
  // state   | meaning
  // IDLE    | after reset/clear, behaves like ACTIVE
  // ACTIVE  | no loop or loop running (cur_valid qualifies)
  // RESTORE | one cycle, reload working loop from lifo_rdata
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESTORE} state_t;

  state_t              state, state_nx;
  logic                cur_valid, cur_valid_nx;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nx;
  logic [ITER_W-1:0]   cur_iter, cur_iter_nx;
  logic [3:0]          depth_q, depth_nx;
  logic                error_q, error_nx;
  logic                jump_req_q, jump_req_nx;
  logic [ADDR_W-1:0]   jump_addr_q, jump_addr_nx;
  logic                push, pop;
  logic                brk;
  logic [ITER_W-1:0]   iter_load;
  logic                multi;

`ifdef PMCC_LOOP_INFINITE_EN
  assign brk       = bus.loop_break;
  assign iter_load = bus.iterations;
`else
  assign brk       = 1'b0;
  assign iter_load = (bus.iterations == '0) ? ITER_W'(1) : bus.iterations;
`endif

  assign multi = (bus.loop_start & bus.loop_end) | (bus.loop_start & brk) | (bus.loop_end & brk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_valid   <= 1'b0;
      cur_addr    <= '0;
      cur_iter    <= '0;
      depth_q     <= '0;
      error_q     <= 1'b0;
      jump_req_q  <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state       <= state_nx;
      cur_valid   <= cur_valid_nx;
      cur_addr    <= cur_addr_nx;
      cur_iter    <= cur_iter_nx;
      depth_q     <= depth_nx;
      error_q     <= error_nx;
      jump_req_q  <= jump_req_nx;
      jump_addr_q <= jump_addr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cur_valid_nx = cur_valid;
    cur_addr_nx  = cur_addr;
    cur_iter_nx  = cur_iter;
    depth_nx     = depth_q;
    error_nx     = error_q;
    jump_req_nx  = 1'b0;
    jump_addr_nx = jump_addr_q;
    push         = 1'b0;
    pop          = 1'b0;
    case (state)
      ST_IDLE, ST_ACTIVE: begin
        state_nx = ST_ACTIVE;
        if (multi) begin
          error_nx = 1'b1;
        end else if (bus.loop_start) begin
          if (cur_valid && (bus.lifo_full || depth_q == 4'(DEPTH + 1))) begin
            error_nx = 1'b1;
          end else begin
            push         = cur_valid;
            cur_addr_nx  = bus.start_addr;
            cur_iter_nx  = iter_load;
            cur_valid_nx = 1'b1;
            depth_nx     = depth_q + 4'd1;
          end
        end else if (bus.loop_end || brk) begin
          if (!cur_valid) begin
            error_nx = 1'b1;
          end else if (brk || cur_iter == ITER_W'(1)) begin
            depth_nx = depth_q - 4'd1;
            if (bus.lifo_empty) begin
              cur_valid_nx = 1'b0;
            end else begin
              pop      = 1'b1;
              state_nx = ST_RESTORE;
            end
          end else begin
            // cur_iter==0 only exists with infinite loops enabled: jump, never decrement
            jump_req_nx  = 1'b1;
            jump_addr_nx = cur_addr;
            if (cur_iter > ITER_W'(1)) cur_iter_nx = cur_iter - ITER_W'(1);
          end
        end
      end
      ST_RESTORE: begin
        if (bus.loop_start || bus.loop_end || brk) error_nx = 1'b1;
        {cur_addr_nx, cur_iter_nx} = bus.lifo_rdata;
        cur_valid_nx = 1'b1;
        state_nx     = ST_ACTIVE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (bus.clear) begin
      state_nx     = ST_IDLE;
      cur_valid_nx = 1'b0;
      cur_addr_nx  = '0;
      cur_iter_nx  = '0;
      depth_nx     = '0;
      error_nx     = 1'b0;
      jump_req_nx  = 1'b0;
      jump_addr_nx = '0;
      push         = 1'b0;
      pop          = 1'b0;
    end
  end

  assign bus.busy       = (state == ST_RESTORE);
  assign bus.jump_req   = jump_req_q;
  assign bus.jump_addr  = jump_addr_q;
  assign bus.depth      = depth_q;
  assign bus.error      = error_q;
  assign bus.lifo_push  = push;
  assign bus.lifo_pop   = pop;
  assign bus.lifo_wdata = push ? {cur_addr, cur_iter} : '0;
endmodule

// File: tb/tb_pmcc_loop_ctrl.sv
// Scoreboard bench for pmcc_loop_ctrl with a behavioural LIFO and a loop-stack reference model.
// Build with or without PMCC_LOOP_INFINITE_EN.
module tb_pmcc_loop_ctrl;
  localparam int ADDR_W = 10;
  localparam int ITER_W = 14;
  localparam int DEPTH  = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ITER_W-1:0] n;
  } ctx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmcc_loop_ctrl_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();
  pmcc_loop_ctrl #(.ADDR_W(ADDR_W), .ITER_W(ITER_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  // behavioural loop LIFO, registered read data
  logic [ADDR_W+ITER_W-1:0] lifo_q[$];
  int lifo_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.clear) begin
      lifo_q.delete();
      lifo_cnt <= 0;
      bus.lifo_rdata <= '0;
    end else if (bus.lifo_push) begin
      lifo_q.push_back(bus.lifo_wdata);
      lifo_cnt <= lifo_cnt + 1;
    end else if (bus.lifo_pop && lifo_q.size() > 0) begin
      bus.lifo_rdata <= lifo_q.pop_back();
      lifo_cnt <= lifo_cnt - 1;
    end
  end
  assign bus.lifo_full  = (lifo_cnt == DEPTH);
  assign bus.lifo_empty = (lifo_cnt == 0);

  int checks = 0;
  int errors = 0;

  // reference model: stack of open loops, last entry is the running loop
  ctx_t ms[$];
  bit   exp_err;
  logic [ADDR_W-1:0] jump_q[$];
  logic [ADDR_W+ITER_W-1:0] push_q[$];
  int   exp_pops;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [ADDR_W+ITER_W-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.jump_req) begin
          if (jump_q.size() == 0) chk("unexpected_jump", 32'(bus.jump_addr), 32'hdead);
          else chk("jump_addr", 32'(bus.jump_addr), 32'(jump_q.pop_front()));
        end
        if (bus.lifo_push) begin
          if (push_q.size() == 0) chk("unexpected_push", 32'(bus.lifo_wdata), 32'hdead);
          else begin
            w = push_q.pop_front();
            chk("push_wdata", 32'(bus.lifo_wdata), 32'(w));
          end
        end
        if (bus.lifo_pop) begin
          chk("pop_expected", 32'(exp_pops > 0), 32'd1);
          if (exp_pops > 0) exp_pops--;
        end
        if (bus.lifo_push && bus.lifo_pop) chk("push_pop_overlap", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.loop_start = 1'b0;
    bus.loop_end   = 1'b0;
    bus.clear      = 1'b0;
`ifdef PMCC_LOOP_INFINITE_EN
    bus.loop_break = 1'b0;
`endif
  endtask

  task automatic check_state(string name);
    @(negedge clk);
    #1;
    chk({name, "_depth"}, 32'(bus.depth), 32'(ms.size()));
    chk({name, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_jumps_missing"}, 32'(jump_q.size()), 32'd0);
    chk({name, "_push_missing"}, 32'(push_q.size() + exp_pops), 32'd0);
  endtask

  function automatic logic [ITER_W-1:0] eff_iter(logic [ITER_W-1:0] it);
`ifdef PMCC_LOOP_INFINITE_EN
    return it;
`else
    return (it == 0) ? ITER_W'(1) : it;
`endif
  endfunction

  task automatic op_start(logic [ADDR_W-1:0] a, logic [ITER_W-1:0] it);
    ctx_t c;
    if (ms.size() == DEPTH + 1) exp_err = 1'b1;
    else begin
      if (ms.size() > 0) push_q.push_back(ms[ms.size()-1]);
      c.a = a;
      c.n = eff_iter(it);
      ms.push_back(c);
    end
    @(posedge clk); #1;
    bus.loop_start = 1'b1; bus.start_addr = a; bus.iterations = it;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic op_end(bit brk, bit restore_strobe);
    bit popping = 1'b0;
    if (ms.size() == 0) exp_err = 1'b1;
    else if (brk || ms[ms.size()-1].n == 1) begin
      void'(ms.pop_back());
      if (ms.size() > 0) begin
        exp_pops++;
        popping = 1'b1;
      end
    end else begin
      jump_q.push_back(ms[ms.size()-1].a);
      if (ms[ms.size()-1].n > 1) ms[ms.size()-1].n = ms[ms.size()-1].n - 1;
    end
    @(posedge clk); #1;
`ifdef PMCC_LOOP_INFINITE_EN
    bus.loop_break = brk;
`endif
    bus.loop_end = !brk;
    @(posedge clk); #1;
    idle_inputs();
    if (popping) begin
      chk("busy_in_restore", 32'(bus.busy), 32'd1);
      if (restore_strobe) begin
        bus.loop_start = 1'b1;
        exp_err = 1'b1;
      end
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic op_both();
    exp_err = 1'b1;
    @(posedge clk); #1;
    bus.loop_start = 1'b1; bus.loop_end = 1'b1; bus.start_addr = 10'h3aa; bus.iterations = 14'd5;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    ms.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.start_addr = '0;
    bus.iterations = '0;
    exp_err = 1'b0;
    exp_pops = 0;
    fork monitor(); join_none
    #23 rst = 1'b0;

    check_state("reset");
    chk("reset_jump_addr", 32'(bus.jump_addr), 32'd0);
    chk("reset_wdata", 32'(bus.lifo_wdata), 32'd0);

    // single loop
    op_start(10'h040, 14'd3);
    for (int i = 0; i < 3; i++) op_end(1'b0, 1'b0);
    check_state("single");

    // nesting
    op_start(10'h010, 14'd2);
    op_start(10'h020, 14'd2);
    check_state("nest_push");
    op_end(1'b0, 1'b0);
    op_end(1'b0, 1'b0);
    op_end(1'b0, 1'b0);
    op_end(1'b0, 1'b0);
    check_state("nest_done");

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) op_start(ADDR_W'(i * 16 + 5), 14'd2);
    check_state("full");
    op_start(10'h3ff, 14'd1);
    check_state("overflow");
    op_end(1'b0, 1'b0);
    check_state("overflow_addr_kept");
    do_clear();
    check_state("clear_after_overflow");

    // protocol errors
    op_end(1'b0, 1'b0);
    check_state("end_at_depth0");
    do_clear();
    op_start(10'h100, 14'd1);
    op_both();
    check_state("start_end_same_cycle");
    do_clear();
    op_start(10'h030, 14'd1);
    op_start(10'h031, 14'd1);
    op_end(1'b0, 1'b1);
    check_state("strobe_in_restore");
    op_end(1'b0, 1'b0);
    do_clear();
    check_state("clear");

    // iterations == 0
`ifdef PMCC_LOOP_INFINITE_EN
    op_start(10'h011, 14'd2);
    op_start(10'h055, 14'd0);
    for (int i = 0; i < 100; i++) op_end(1'b0, 1'b0);
    check_state("infinite_jumps");
    op_end(1'b1, 1'b0);
    check_state("break_restore");
    op_end(1'b0, 1'b0);
    op_end(1'b0, 1'b0);
    check_state("break_outer_done");
    op_end(1'b1, 1'b0);
    check_state("break_no_loop");
    do_clear();
`else
    op_start(10'h055, 14'd0);
    op_end(1'b0, 1'b0);
    check_state("iter0_as_1");
`endif

    // randomized
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) op_start(ADDR_W'($urandom_range(0, 1023)), ITER_W'($urandom_range(0, 3)));
      else if (r < 88) op_end(1'b0, ($urandom_range(0, 9) == 0));
`ifdef PMCC_LOOP_INFINITE_EN
      else if (r < 92) op_end(1'b1, 1'b0);
`else
      else if (r < 92) op_end(1'b0, 1'b0);
`endif
      else if (r < 95) op_both();
      else do_clear();
      check_state("rand");
    end

    // async reset in the middle of RESTORE
    do_clear();
    op_start(10'h0a0, 14'd1);
    op_start(10'h0b0, 14'd1);
    exp_pops++;
    @(posedge clk); #1;
    bus.loop_end = 1'b1;
    @(posedge clk); #1;
    bus.loop_end = 1'b0;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_depth", 32'(bus.depth), 32'd0);
    chk("rst_pulses", 32'({bus.jump_req, bus.lifo_push, bus.lifo_pop, bus.error}), 32'd0);
    chk("rst_jump_addr", 32'(bus.jump_addr), 32'd0);
    ms.delete();
    exp_err = 1'b0;
    #20 rst = 1'b0;
    check_state("after_async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmcc_loop_ctrl.md
Name: pmcc_loop_ctrl

Overview:
- Loop sequencer for the PMC coprocessor. It is the driving and consuming end of the loop LIFO.
- Takes LOOP-begin and LOOP-end strobes from the instruction decoder and holds the active loop (start address, remaining iterations) in a working register.
- On nesting, spills the outer loop context into the LIFO; when the inner loop completes, pops and restores it.
- Issues one-cycle jump requests to the PC logic.

Parameters:
ADDR_W, 10, width of loop start address (matches LIFO entry start_address field)
ITER_W, 14, width of iteration count (matches LIFO entry iterations field)
DEPTH, 10, LIFO depth; max nesting level = DEPTH+1

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous active-high soft clear (coprocessor restart); same effect as rst
loop_start  input  1  decoder strobe: LOOP instruction
start_addr  input  ADDR_W  address of first body instruction
iterations  input  ITER_W  total body executions requested
loop_end  input  1  decoder strobe: end-of-body instruction
busy  output  1  controller restoring from LIFO; decoder must stall
jump_req  output  1  one-cycle pulse: PC must load jump_addr
jump_addr  output  ADDR_W  target for jump_req
depth  output  4  current nesting level, 0..DEPTH+1
error  output  1  sticky protocol error
lifo_push  output  1  push strobe to loop LIFO
lifo_wdata  output  ADDR_W+ITER_W  {start_address, iterations} pushed
lifo_pop  output  1  pop strobe to loop LIFO
lifo_rdata  input  ADDR_W+ITER_W  LIFO read data, valid the cycle after lifo_pop
lifo_full  input  1  LIFO full
lifo_empty  input  1  LIFO empty

Behaviour:
- Reset/clear: state IDLE.
  - cur_valid=0, cur_addr=0, cur_iter=0, depth=0.
  - All outputs 0: busy, jump_req, jump_addr, error, lifo_push, lifo_pop, lifo_wdata.
  - rst is asynchronous; clear is sampled on clk.
  - Reset mid-RESTORE abandons the pop. The LIFO is reset by the same coprocessor reset.
- States:
  - ACTIVE: covers both no loop and a loop running (cur_valid qualifies).
  - RESTORE: one cycle.
- loop_start in ACTIVE:
  - If cur_valid and lifo_full: set error, ignore the strobe.
  - If cur_valid and not full: lifo_push=1 for one cycle with lifo_wdata={cur_addr,cur_iter}.
  - Then load cur_addr=start_addr, cur_iter=max(iterations,1), cur_valid=1, depth+=1.
- loop_end in ACTIVE with cur_valid=0: set error, ignore.
- loop_end with cur_iter>1:
  - cur_iter-=1.
  - Next cycle: jump_req=1, jump_addr=cur_addr (registered, latency 1).
- loop_end with cur_iter==1:
  - Loop complete, no jump; depth-=1.
  - If lifo_empty: cur_valid=0.
  - Else: lifo_pop=1, go to RESTORE.
- RESTORE:
  - busy=1.
  - Load {cur_addr,cur_iter} from lifo_rdata, cur_valid=1, return to ACTIVE.
  - busy is combinational from state. Any strobe during RESTORE sets error and is ignored.
- loop_start and loop_end in the same cycle: set error, both ignored.
- jump_req, lifo_push and lifo_pop are single-cycle pulses. lifo_push and lifo_pop are never asserted together.
- cur_iter never wraps: decrements only when >1.
- jump_addr holds its last value between pulses.
- error clears only on rst/clear.

Optional Feature:
- Macro PMCC_LOOP_INFINITE_EN.
- Defined:
  - iterations==0 loads cur_iter=0, meaning infinite.
  - loop_end with cur_iter==0 always jumps; cur_iter is not decremented.
  - Adds input loop_break (1 bit). loop_break in ACTIVE with cur_valid forces completion exactly as cur_iter==1 (pop/restore or invalidate), with no jump. loop_break with cur_valid=0 sets error.
- Undefined: iterations==0 treated as 1; no loop_break port.

Test Plan:
- Single loop: loop_start addr=0x040 iter=3, three loop_end strobes -> jump_req pulses with jump_addr=0x040 after 1st and 2nd only; depth 1 -> 0; no LIFO traffic.
- Nesting: outer addr=0x010 iter=2, inner addr=0x020 iter=2.
  - Expect lifo_push with wdata={0x010,2}.
  - Two inner loop_end -> one jump to 0x020, then lifo_pop, busy=1 for one cycle.
  - Next outer loop_end -> jump to 0x010.
- Overflow: 11 nested loop_start (depth=11, LIFO full), 12th loop_start -> error=1, depth stays 11, no lifo_push, cur_addr unchanged.
- Protocol errors: loop_end at depth 0, loop_start+loop_end same cycle, loop_start during RESTORE -> error=1 each case, state unchanged; clear -> error=0, depth=0.
- iterations=0:
  - Without macro: one loop_end -> no jump, depth 0.
  - With PMCC_LOOP_INFINITE_EN: 100 loop_end -> 100 jumps; loop_break -> completion and restore of the outer loop from the LIFO.
- Async reset asserted during RESTORE -> all outputs 0 immediately, busy=0, depth=0.
